// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch front end: FSM states and the
// prefetch entry that pairs an instruction word with its address.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_AW    = 32;
  localparam int FETCH_IW    = 32;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Registered prefetch FIFO of fetch entries; head is read straight from storage,
// so a pushed entry becomes visible the cycle after the push.
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_push,
  input  fetch_entry_t  i_wdata,
  input  logic          i_pop,
  output fetch_entry_t  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == CW'(0));
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage, pointers and occupancy; flush only rewinds, storage keeps stale data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited in-order
// reads, buffers responses, and flushes/restarts on redirect.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter int                    DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   mem_req_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  input  logic                   mem_gnt_i,
  input  logic                   mem_rvalid_i,
  input  logic [INSTR_WIDTH-1:0] mem_rdata_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  input  logic                   redirect_i,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc_i,
  output logic                   misalign_o
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [ADDR_WIDTH-1:0] r_resp_pc;
  logic [CW-1:0]         r_outstanding;
  logic [CW-1:0]         w_outstanding_nxt;
  logic [CW-1:0]         r_discard;
  logic                  r_misalign;

  logic [CW-1:0]         w_fifo_count;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  fetch_entry_t          w_head;
  fetch_entry_t          w_push_entry;
  logic [CW:0]           w_inflight;
  logic                  w_grant;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_redirect_pc;

  // Credits cover both buffered words and words still owed by memory
  assign w_inflight    = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign mem_req_o     = (r_state == RUN) && !redirect_i && !w_fifo_full
                         && (w_inflight < (CW + 1)'(DEPTH));
  assign mem_addr_o    = r_fetch_pc;
  assign w_grant       = mem_req_o && mem_gnt_i;
  assign w_push        = mem_rvalid_i && !redirect_i && (r_discard == CW'(0));
  assign w_pop         = instr_valid_o && instr_ready_i;
  assign w_redirect_pc = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_push_entry  = '{pc: r_resp_pc, instr: mem_rdata_i};

  assign instr_valid_o = !w_fifo_empty;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;
  assign misalign_o    = r_misalign;

  // Boot lasts exactly one cycle; redirects never leave RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BOOT:    w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = BOOT;
    endcase
  end

  // Outstanding count after this cycle's grant and response
  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_grant, mem_rvalid_i})
      2'b10:   w_outstanding_nxt = r_outstanding + CW'(1);
      2'b01:   w_outstanding_nxt = r_outstanding - CW'(1);
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  // State, PCs and counters; a redirect marks every still-owed word as stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      if (redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_discard  <= w_outstanding_nxt;
        r_misalign <= |redirect_pc_i[1:0];
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
        if (w_push)  r_resp_pc  <= r_resp_pc + ADDR_WIDTH'(INSTR_BYTES);
        if (mem_rvalid_i && (r_discard != CW'(0))) r_discard <= r_discard - CW'(1);
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_prefetch_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_i),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_fifo_count),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: address-as-data memory model with
// programmable latency, redirect vector table and hand-written corner sequences.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        misalign_o;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] exp_pc0;
    logic [31:0] exp_pc1;
    logic        exp_mis;
  } vec_t;

  int          n_pass;
  int          n_total;
  int          cyc;
  int          lat;
  int          last_due;
  int          n_grants;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_instr[$];
  int          got_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gpc(input int i);
    return (got_pc.size() > i) ? got_pc[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] ginstr(input int i);
    return (got_instr.size() > i) ? got_instr[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_got();
    got_pc.delete();
    got_instr.delete();
    got_cyc.delete();
  endtask

  task automatic wait_got(input string name, input int n, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (got_pc.size() >= n) break;
      tick();
    end
    check(name, 32'(got_pc.size() >= n), 32'd1);
  endtask

  // Memory: grants sampled before the edge, in-order responses after lat cycles
  initial begin
    cyc = 0; last_due = 0; n_grants = 0;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_o && mem_gnt_i) begin
        int due;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        q_addr.push_back(mem_addr_o);
        q_due.push_back(due);
        last_due = due;
        n_grants++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        q_addr.delete(); q_due.delete();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      end else if (q_due.size() > 0 && q_due[0] == cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = q_addr.pop_front();
        void'(q_due.pop_front());
      end else begin
        mem_rvalid_i = 1'b0;
      end
    end
  end

  // Consumer monitor: records every accepted instruction
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && instr_valid_o && instr_ready_i) begin
        got_pc.push_back(pc_o);
        got_instr.push_back(instr_o);
        got_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    vec_t        vecs[5];
    int          n_bad;
    logic [31:0] a0;

    vecs[0] = '{32'h0000_0100, 3, 32'h0000_0100, 32'h0000_0104, 1'b0};
    vecs[1] = '{32'h0000_0102, 1, 32'h0000_0100, 32'h0000_0104, 1'b1};
    vecs[2] = '{32'h0000_0203, 2, 32'h0000_0200, 32'h0000_0204, 1'b1};
    vecs[3] = '{32'hFFFF_FFFE, 1, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_0040, 3, 32'h0000_0040, 32'h0000_0044, 1'b0};

    n_pass = 0; n_total = 0;
    rst_n = 1'b0; mem_gnt_i = 1'b1; lat = 1;
    instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_req",   32'(mem_req_o),     32'd0);
    check("rst_addr",  mem_addr_o,         32'h0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_instr", instr_o,            32'h0);
    check("rst_pc",    pc_o,               32'h0);
    check("rst_mis",   32'(misalign_o),    32'd0);

    tick(); rst_n = 1'b1;
    @(negedge clk);
    check("boot_req", 32'(mem_req_o), 32'd0);
    tick();
    @(negedge clk);
    check("first_req",  32'(mem_req_o), 32'd1);
    check("first_addr", mem_addr_o,     32'h0);

    // Decode stalled: credits cap outstanding+buffered at DEPTH
    repeat (10) tick();
    @(negedge clk);
    check("stall_grants", 32'(n_grants),     32'd4);
    check("stall_req",    32'(mem_req_o),     32'd0);
    check("stall_valid",  32'(instr_valid_o), 32'd1);
    check("stall_instr",  instr_o,            32'h0);
    check("stall_pc",     pc_o,               32'h0);

    tick(); instr_ready_i = 1'b1; clear_got();
    repeat (24) tick();
    check("stream_count", 32'(got_pc.size() >= 16), 32'd1);
    n_bad = 0;
    for (int i = 0; i < 16; i++) if (gpc(i) !== 32'(4 * i)) n_bad++;
    check("stream_order", 32'(n_bad), 32'd0);
    n_bad = 0;
    for (int i = 0; i < 16; i++) if (ginstr(i) !== gpc(i)) n_bad++;
    check("stream_data", 32'(n_bad), 32'd0);
    n_bad = 0;
    for (int i = 0; i + 1 < 16 && i + 1 < got_cyc.size(); i++)
      if (got_cyc[i+1] != got_cyc[i] + 1) n_bad++;
    check("stream_gaps", 32'(n_bad), 32'd0);

    // Redirect table: stale words dropped, restart at aligned target
    for (int v = 0; v < 5; v++) begin
      lat = vecs[v].lat;
      repeat (8) tick();
      redirect_i = 1'b1; redirect_pc_i = vecs[v].target;
      tick();
      redirect_i = 1'b0; clear_got();
      @(negedge clk);
      check($sformatf("v%0d_valid_n1", v), 32'(instr_valid_o), 32'd0);
      check($sformatf("v%0d_req_n1", v),   32'(mem_req_o),     32'd1);
      check($sformatf("v%0d_addr_n1", v),  mem_addr_o,         vecs[v].exp_pc0);
      wait_got($sformatf("v%0d_wait", v), 2, 30);
      check($sformatf("v%0d_pc0", v),    gpc(0),           vecs[v].exp_pc0);
      check($sformatf("v%0d_instr0", v), ginstr(0),        vecs[v].exp_pc0);
      check($sformatf("v%0d_pc1", v),    gpc(1),           vecs[v].exp_pc1);
      check($sformatf("v%0d_mis", v),    32'(misalign_o),  32'(vecs[v].exp_mis));
    end

    // Grant withheld: request and address must hold
    tick(); mem_gnt_i = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    a0 = mem_addr_o;
    check("hold_req", 32'(mem_req_o), 32'd1);
    n_bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      if (!mem_req_o || mem_addr_o !== a0) n_bad++;
    end
    check("hold_stable", 32'(n_bad), 32'd0);
    tick(); clear_got(); mem_gnt_i = 1'b1;
    wait_got("hold_wait", 1, 20);
    check("hold_resume_pc",    gpc(0),    a0);
    check("hold_resume_instr", ginstr(0), a0);

    // Async reset with two entries buffered
    tick(); instr_ready_i = 1'b0; lat = 1;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0082;
    tick(); redirect_i = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("pre_rst_valid", 32'(instr_valid_o), 32'd1);
    check("pre_rst_pc",    pc_o,               32'h0000_0080);
    check("pre_rst_mis",   32'(misalign_o),    32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",   32'(mem_req_o),     32'd0);
    check("arst_addr",  mem_addr_o,         32'h0);
    check("arst_valid", 32'(instr_valid_o), 32'd0);
    check("arst_instr", instr_o,            32'h0);
    check("arst_pc",    pc_o,               32'h0);
    check("arst_mis",   32'(misalign_o),    32'd0);
    tick(); clear_got();
    tick(); rst_n = 1'b1; instr_ready_i = 1'b1;
    wait_got("refetch_wait", 2, 20);
    check("refetch_pc0",    gpc(0),    32'h0);
    check("refetch_instr0", ginstr(0), 32'h0);
    check("refetch_pc1",    gpc(1),    32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
